// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch queue.
//   ifq_entry_s  : one queued instruction (address, data, RVC and illegal flags)
//   ILEN_C/ILEN_W: address increments for compressed / full-width instructions
//   RVC_OPC_FULL : low-bit opcode pattern that marks a 32-bit instruction
//   make_entry() : builds an entry from raw fetch data and derives its flags
package riscv_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        compressed;
    logic        illegal;
  } ifq_entry_s;

  localparam logic [31:0] ILEN_C       = 32'd2;
  localparam logic [31:0] ILEN_W       = 32'd4;
  localparam logic [1:0]  RVC_OPC_FULL = 2'b11;

  // Upper halfword is zeroed for compressed instructions so decode never
  // sees stale fetch bits there.
  function automatic ifq_entry_s make_entry(input logic [31:0] addr,
                                            input logic [31:0] data);
    ifq_entry_s e;
    e.addr       = addr;
    e.compressed = (data[1:0] != RVC_OPC_FULL);
    e.illegal    = (data[15:0] == 16'h0000);
    e.data       = e.compressed ? {16'h0000, data[15:0]} : data;
    return e;
  endfunction

endpackage

// File: rtl/riscv_ifq_fifo.sv
// Generic DEPTH-entry FIFO storage with pointers and occupancy count.
//   clock, reset    : rising-edge clock, async active-low reset
//   clr             : synchronous clear of pointers and count
//   push/wdata      : write one entry (caller guarantees !full)
//   pop/rdata       : drop head entry (caller guarantees !empty); rdata = head
//   count/empty/full: registered occupancy status
// Storage itself is not reset; only pointers and count are.
module riscv_ifq_fifo
  import riscv_pkg::*;
#(
  parameter  int  DEPTH   = 4,
  parameter  type entry_t = ifq_entry_s,
  localparam int  CNT_W   = $clog2(DEPTH) + 1,
  localparam int  PTR_W   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers are exactly log2(DEPTH) bits, so increments wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clr) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/riscv_ifq.sv
// Instruction fetch queue between fetch unit and decode.
//   clock, reset      : rising-edge clock, async active-low reset
//   ifu_vld/addr/data : instruction from fetch; ifu_rdy = queue can accept
//   flush             : discard queue contents and sequence state
//   dec_vld/rdy       : head handshake to decode; dec_addr/data/compressed/
//                       illegal describe the head entry
//   ifq_count         : occupancy 0..DEPTH
//   seq_err           : sticky flag, a non-sequential address was enqueued
// Optional macro RISCV_IFQ_BYPASS_EN: when the queue is empty, the incoming
// instruction is presented to decode in the same cycle and, if taken, never
// written to storage.
module riscv_ifq
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ifu_vld,
  input  logic [31:0]      ifu_addr,
  input  logic [31:0]      ifu_data,
  output logic             ifu_rdy,
  input  logic             flush,
  output logic             dec_vld,
  input  logic             dec_rdy,
  output logic [31:0]      dec_addr,
  output logic [31:0]      dec_data,
  output logic             dec_compressed,
  output logic             dec_illegal,
  output logic [CNT_W-1:0] ifq_count,
  output logic             seq_err
);

  ifq_entry_s in_e, head_e, fifo_e;
  logic       empty, full, push, pop, enq;
  logic       rdy_q;
  logic       exp_vld_q, exp_vld_d;
  logic [31:0] exp_addr_q, exp_addr_d;
  logic       seq_err_q, seq_err_d;

  assign in_e = make_entry(ifu_addr, ifu_data);

  // rdy_q holds ifu_rdy low through reset and rises one edge after release.
  // Readiness uses the registered count only, so a full queue will not
  // admit an enqueue even when decode drains in the same cycle.
  assign ifu_rdy = rdy_q & ~full & ~flush;
  assign enq     = ifu_vld & ifu_rdy;

`ifdef RISCV_IFQ_BYPASS_EN
  logic byp;
  assign byp     = empty & ifu_vld & rdy_q & ~flush;
  assign dec_vld = (~empty | byp) & ~flush;
  assign head_e  = empty ? in_e : fifo_e;
  // A bypassed instruction taken by decode is never written.
  assign push    = enq & ~(byp & dec_rdy);
  assign pop     = ~empty & dec_vld & dec_rdy;
`else
  assign dec_vld = ~empty & ~flush;
  assign head_e  = fifo_e;
  assign push    = enq;
  assign pop     = dec_vld & dec_rdy;
`endif

  riscv_ifq_fifo #(.DEPTH(DEPTH), .entry_t(ifq_entry_s)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clr   (flush),
    .push  (push),
    .wdata (in_e),
    .pop   (pop),
    .rdata (fifo_e),
    .count (ifq_count),
    .empty (empty),
    .full  (full)
  );

  // Sequence checker: every enqueue, bypassed or not, predicts the next
  // address; a mismatch against a valid prediction sets the sticky error.
  always_comb begin
    exp_vld_d  = exp_vld_q;
    exp_addr_d = exp_addr_q;
    seq_err_d  = seq_err_q;
    if (flush) begin
      exp_vld_d = 1'b0;
      seq_err_d = 1'b0;
    end else if (enq) begin
      if (exp_vld_q && (ifu_addr != exp_addr_q)) seq_err_d = 1'b1;
      exp_addr_d = ifu_addr + (in_e.compressed ? ILEN_C : ILEN_W);
      exp_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_q      <= 1'b0;
      exp_vld_q  <= 1'b0;
      exp_addr_q <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      exp_vld_q  <= exp_vld_d;
      exp_addr_q <= exp_addr_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign dec_addr       = head_e.addr;
  assign dec_data       = head_e.data;
  assign dec_compressed = head_e.compressed;
  assign dec_illegal    = head_e.illegal;
  assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_riscv_ifq.sv
module tb_riscv_ifq;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef RISCV_IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ifu_vld = 1'b0;
  logic [31:0]      ifu_addr = '0;
  logic [31:0]      ifu_data = '0;
  logic             ifu_rdy;
  logic             flush = 1'b0;
  logic             dec_vld;
  logic             dec_rdy = 1'b0;
  logic [31:0]      dec_addr, dec_data;
  logic             dec_compressed, dec_illegal;
  logic [CNT_W-1:0] ifq_count;
  logic             seq_err;

  always #5 clock = ~clock;

  riscv_ifq #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ifu_vld(ifu_vld), .ifu_addr(ifu_addr), .ifu_data(ifu_data), .ifu_rdy(ifu_rdy),
    .flush(flush),
    .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_addr(dec_addr), .dec_data(dec_data),
    .dec_compressed(dec_compressed), .dec_illegal(dec_illegal),
    .ifq_count(ifq_count), .seq_err(seq_err)
  );

  // Reference model: a queue of instructions plus the sequence prediction.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          c;
    bit          i;
  } ment_t;

  ment_t       q[$];
  bit          started = 0;
  bit          m_expv = 0;
  logic [31:0] m_expa = '0;
  bit          m_serr = 0;
  int          n_chk = 0;
  int          n_err = 0;

  function automatic ment_t mk(input logic [31:0] a, input logic [31:0] d);
    ment_t e;
    e.addr = a;
    e.c    = (d[1:0] != 2'b11);
    e.i    = (d[15:0] == 16'h0);
    e.data = e.c ? (d & 32'h0000_FFFF) : d;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, check against model, advance one clock.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input bit r, input bit f, output bit acc);
    bit    m_rdy, m_dv, enq, deq, was_empty;
    ment_t hd, e;
    ifu_vld = v; ifu_addr = a; ifu_data = d; dec_rdy = r; flush = f;
    #1;
    m_rdy = started && (q.size() < DEPTH) && !f;
    m_dv  = !f && ((q.size() > 0) || (BYP && started && v));
    hd    = (q.size() > 0) ? q[0] : mk(a, d);
    chk("ifu_rdy", 32'(ifu_rdy), 32'(m_rdy));
    chk("dec_vld", 32'(dec_vld), 32'(m_dv));
    chk("count",   32'(ifq_count), 32'(q.size()));
    chk("seq_err", 32'(seq_err), 32'(m_serr));
    if (m_dv) begin
      chk("dec_addr", dec_addr, hd.addr);
      chk("dec_data", dec_data, hd.data);
      chk("dec_comp", 32'(dec_compressed), 32'(hd.c));
      chk("dec_ill",  32'(dec_illegal), 32'(hd.i));
    end
    enq = v && m_rdy;
    deq = m_dv && r;
    acc = enq;
    @(posedge clock);
    if (f) begin
      q.delete(); m_expv = 0; m_serr = 0;
    end else begin
      was_empty = (q.size() == 0);
      if (enq) begin
        e = mk(a, d);
        if (m_expv && a != m_expa) m_serr = 1;
        m_expa = a + (e.c ? 32'd2 : 32'd4);
        m_expv = 1;
      end
      if (deq && !was_empty) void'(q.pop_front());
      if (enq && !(deq && was_empty)) q.push_back(e);
    end
    started = 1;
    @(negedge clock);
  endtask

  task automatic peek();
    ifu_vld = 1'b0; flush = 1'b0; dec_rdy = 1'b0;
    #1;
  endtask

  bit          acc, hold;
  bit          cv, cr, cf;
  logic [31:0] ca, cd, na, rv;

  initial begin
    // Reset state
    #1;
    chk("rst_ifu_rdy", 32'(ifu_rdy), 32'd0);
    chk("rst_dec_vld", 32'(dec_vld), 32'd0);
    chk("rst_count",   32'(ifq_count), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, acc);

    // Single enqueue, one-cycle latency
    cycle(1, 32'h200, 32'h0050_0093, 0, 0, acc);
    peek();
    chk("t1_vld",  32'(dec_vld), 32'd1);
    chk("t1_addr", dec_addr, 32'h200);
    chk("t1_comp", 32'(dec_compressed), 32'd0);
    chk("t1_cnt",  32'(ifq_count), 32'd1);
    chk("t1_serr", 32'(seq_err), 32'd0);
    cycle(0, 0, 0, 0, 1, acc);

    // Fill, then full-queue bubble on simultaneous drain
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h200 + 32'(4*i), 32'h13, 0, 0, acc);
    peek();
    chk("t2_full_rdy", 32'(ifu_rdy), 32'd0);
    chk("t2_full_cnt", 32'(ifq_count), 32'd4);
    cycle(1, 32'h210, 32'h13, 1, 0, acc);
    chk("t2_no_enq", 32'(acc), 32'd0);
    peek();
    chk("t2_cnt",  32'(ifq_count), 32'd3);
    chk("t2_rdy",  32'(ifu_rdy), 32'd1);
    chk("t2_head", dec_addr, 32'h204);
    cycle(0, 0, 0, 0, 1, acc);

    // Compressed and illegal flags
    cycle(1, 32'h300, 32'h0000_4501, 0, 0, acc);
    cycle(1, 32'h302, 32'h0000_0000, 0, 0, acc);
    peek();
    chk("t3_comp0", 32'(dec_compressed), 32'd1);
    chk("t3_data0", dec_data, 32'h0000_4501);
    cycle(0, 0, 0, 1, 0, acc);
    peek();
    chk("t3_comp1", 32'(dec_compressed), 32'd1);
    chk("t3_ill1",  32'(dec_illegal), 32'd1);
    chk("t3_serr",  32'(seq_err), 32'd0);
    cycle(0, 0, 0, 0, 1, acc);

    // Sequence error, sticky, cleared by flush
    cycle(1, 32'h200, 32'h13, 0, 0, acc);
    cycle(1, 32'h208, 32'h13, 0, 0, acc);
    peek();
    chk("t4_serr",  32'(seq_err), 32'd1);
    cycle(0, 0, 0, 1, 0, acc);
    peek();
    chk("t4_stick", 32'(seq_err), 32'd1);
    cycle(0, 0, 0, 0, 1, acc);
    peek();
    chk("t4_fl_serr", 32'(seq_err), 32'd0);
    chk("t4_fl_cnt",  32'(ifq_count), 32'd0);
    cycle(1, 32'h400, 32'h13, 0, 0, acc);
    peek();
    chk("t4_post", 32'(seq_err), 32'd0);
    cycle(0, 0, 0, 0, 1, acc);

    // Flush with pending handshakes, then async reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1, 32'h600 + 32'(4*i), 32'h13, 0, 0, acc);
    peek();
    chk("t5_cnt3", 32'(ifq_count), 32'd3);
    cycle(1, 32'h60C, 32'h13, 1, 1, acc);
    chk("t5_fl_acc", 32'(acc), 32'd0);
    peek();
    chk("t5_cnt0", 32'(ifq_count), 32'd0);
    cycle(1, 32'h700, 32'h13, 0, 0, acc);
    cycle(1, 32'h704, 32'h13, 0, 0, acc);
    reset = 1'b0;
    #1;
    chk("t5_rst_vld", 32'(dec_vld), 32'd0);
    chk("t5_rst_cnt", 32'(ifq_count), 32'd0);
    chk("t5_rst_rdy", 32'(ifu_rdy), 32'd0);
    q.delete(); m_expv = 0; m_serr = 0; started = 0;
    @(negedge clock);
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, acc);

    // Bypass (or one-cycle latency without it)
    cycle(1, 32'h500, 32'h00A0_0113, 1, 0, acc);
    peek();
    chk("t6_cnt", 32'(ifq_count), BYP ? 32'd0 : 32'd1);
    cycle(0, 0, 0, 0, 1, acc);

    // Address wrap is sequential
    cycle(1, 32'hFFFF_FFFC, 32'h13, 1, 0, acc);
    cycle(1, 32'h0, 32'h13, 1, 0, acc);
    peek();
    chk("t7_wrap", 32'(seq_err), 32'd0);
    cycle(0, 0, 0, 0, 1, acc);

    // Randomized traffic against the model
    hold = 0; na = 32'h1000; cv = 0; ca = '0; cd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        cv = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
          rv = $urandom;
          na = rv & 32'hFFFF_FFFE;
        end
        ca = na;
        rv = $urandom;
        case ($urandom_range(0, 3))
          0:       cd = {rv[31:16], rv[15:2], 2'b01};
          1:       cd = {rv[31:16], 16'h0000};
          default: cd = {rv[31:2], 2'b11};
        endcase
      end
      cr = ($urandom_range(0, 2) != 0);
      cf = ($urandom_range(0, 40) == 0);
      cycle(cv, ca, cd, cr, cf, acc);
      if (acc) begin
        na   = ca + ((cd[1:0] != 2'b11) ? 32'd2 : 32'd4);
        hold = 0;
      end else begin
        hold = cv && !cf;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_ifq.md
Name: riscv_ifq

Overview:
Instruction fetch queue between the fetch unit and decode. It buffers aligned instructions (32-bit, or 16-bit compressed) produced by the fetch unit and presents them to decode over a valid/ready handshake. Each entry is tagged with compressed and illegal-encoding flags. It also checks that fetched addresses are sequential. Flush support lets a redirect discard everything in flight.

Parameters:
DEPTH, 4, number of queue entries; power of two, >=2
CNT_W, $clog2(DEPTH)+1, derived localparam; occupancy counter width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
ifu_vld  in  1  fetch unit presents an instruction
ifu_addr  in  32  instruction address
ifu_data  in  32  instruction bits; [31:16] don't-care when compressed
ifu_rdy  out  1  queue can accept; fetch unit holds ifu_* stable while vld & !rdy
flush  in  1  discard all queued entries and sequence state
dec_vld  out  1  head entry valid
dec_rdy  in  1  decode accepts head
dec_addr  out  32  head address
dec_data  out  32  head instruction; [31:16] forced 0 when compressed
dec_compressed  out  1  head is 16-bit (data[1:0]!=2'b11)
dec_illegal  out  1  head low halfword is 16'h0000 (defined-illegal encoding)
ifq_count  out  CNT_W  occupancy 0..DEPTH
seq_err  out  1  sticky: non-sequential enqueue address detected

Behaviour:
- Reset (reset=0, async): pointers, count, exp_vld and seq_err cleared. dec_vld=0, ifq_count=0, seq_err=0. ifu_rdy=0 while reset is low, then 1 from the first cycle after release. dec_addr/dec_data are don't-care while dec_vld=0.
- Enqueue on ifu_vld & ifu_rdy. Dequeue on dec_vld & dec_rdy.
- ifu_rdy = !full, derived from registered count only. No combinational path from dec_rdy.
- Consequence: when full, a same-cycle dequeue does not admit an enqueue; one bubble is accepted.
- Latency: an enqueued instruction appears on dec_* the next cycle when the queue was empty (no bypass).
- Order is strictly FIFO. Pointers are log2(DEPTH) bits and wrap naturally.
- Count update per cycle: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- On simultaneous enqueue and dequeue at count=1, the new entry becomes the head next cycle with no gap in dec_vld.
- Flags are computed at enqueue and stored per entry: compressed = ifu_data[1:0]!=2'b11; illegal = ifu_data[15:0]==16'h0.
- Sequence check:
  - Registers exp_vld and exp_addr.
  - On enqueue with exp_vld=1 and ifu_addr!=exp_addr, seq_err is set.
  - Every enqueue then loads exp_addr = ifu_addr + (compressed ? 2 : 4) as 32-bit wrapping arithmetic (32'hFFFF_FFFC + 4 = 0), and sets exp_vld=1.
- Flush (synchronous, one cycle):
  - While flush=1, dec_vld is forced to 0 and ifu_rdy to 0, so no handshakes occur.
  - Next cycle: count=0, pointers=0, exp_vld=0, seq_err=0.
  - The first enqueue after a flush never flags seq_err.
  - Flush held for several cycles keeps the queue empty throughout.
- seq_err stays 1 until reset or flush; further mismatches have no additional effect.
- Storage is not reset; only valid/state bits are.

Optional Feature:
RISCV_IFQ_BYPASS_EN:
- Defined: when the queue is empty, flush=0 and ifu_vld=1, the incoming instruction is presented combinationally on dec_* in the same cycle, with flags computed on the fly.
  - If dec_rdy=1 it is consumed without being written and count stays 0.
  - Otherwise it is written normally.
  - The sequence check runs identically either way.
- Undefined: minimum latency is one cycle as above, and there is no combinational path from ifu_* to dec_*.

Decomposition:
- Shared package riscv_pkg:
  - ifq_entry_s typedef (addr[31:0], data[31:0], compressed, illegal).
  - Constants ILEN_C=2 and ILEN_W=4 (address increments).
  - RVC_OPC_FULL=2'b11.
- Sub-module riscv_ifq_fifo: generic DEPTH-entry storage plus pointers/count, parameterised on entry type.
- riscv_ifq top holds flag generation, the sequence checker, flush gating and the bypass mux.

Test Plan:
- Reset release, then enqueue 0x200/0x00500093 -> next cycle dec_vld=1, dec_addr=0x200, dec_compressed=0, ifq_count=1, seq_err=0.
- Hold dec_rdy=0, enqueue DEPTH=4 words from 0x200 step 4 -> ifu_rdy=0 at count=4; raise dec_rdy for one cycle with ifu_vld=1 -> dequeue 0x200 only, count=3, ifu_rdy=1 next cycle.
- Enqueue 0x300/0x00004501 then 0x302/0x00000000 -> first head dec_compressed=1 with dec_data=0x00004501; second head dec_compressed=1, dec_illegal=1; seq_err stays 0.
- Enqueue 0x200 (32-bit) then 0x208 -> seq_err=1 from the following cycle and remains 1; flush -> seq_err=0, count=0; enqueue 0x400 -> seq_err stays 0.
- Fill to count=3, assert flush with ifu_vld=1 and dec_rdy=1 -> no handshakes in the flush cycle, count=0 next cycle; drop reset mid-stream -> dec_vld=0 immediately.
- With RISCV_IFQ_BYPASS_EN, empty queue, dec_rdy=1, enqueue 0x500/0x00A00113 -> dec_vld=1, dec_addr=0x500 the same cycle, count stays 0; without the macro, dec_vld rises the next cycle.
